// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the ownership stage around the fixed-priority arbiter.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Binary index of a one-hot vector; returns 0 for an all-zero vector.
  function automatic logic [31:0] onehot_to_idx(input logic [31:0] vec);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_lock.sv
// Ownership stage: gates requests into an external combinational fixed-priority
// arbiter, latches its grant as a registered owner held for a multi-cycle
// transaction, and releases on done, request drop or hold timeout. A requester
// that timed out is masked for the next arbitration slot.
module arbiter_lock
  import arbiter_pkg::*;
#(
  parameter int NUM      = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDX_W   = (NUM > 1) ? $clog2(NUM) : 1,
  localparam int CNT_W   = $clog2(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM-1:0]   req_i,
  output logic [NUM-1:0]   req_arb_o,
  input  logic [NUM-1:0]   gnt_i,
  input  logic [NUM-1:0]   done_i,
  output logic [NUM-1:0]   owner_o,
  output logic [IDX_W-1:0] owner_idx_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             err_o
);

  state_e             state_q, state_n;
  logic [NUM-1:0]     owner_q, owner_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [NUM-1:0]     mask_q, mask_n;
  logic               timeout_q, timeout_n;
  logic               err_q, err_n;

  // Requests reach the arbiter only while idle, minus any penalised requester.
  always_comb begin
    req_arb_o = (state_q == IDLE) ? (req_i & ~mask_q) : '0;
  end

  // Next-state and next-output decisions for the ownership FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_n   = state_q;
    owner_n   = owner_q;
    idx_n     = idx_q;
    cnt_n     = cnt_q;
    mask_n    = mask_q;
    timeout_n = 1'b0;
    err_n     = err_q;

    case (state_q)
      IDLE: begin
        // The penalty only ever covers one arbitration slot.
        mask_n = '0;
        if (gnt_i != '0) begin
          if ($onehot(gnt_i)) begin
            state_n = OWNED;
            owner_n = gnt_i;
            idx_n   = IDX_W'(onehot_to_idx(32'(gnt_i)));
            cnt_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      OWNED: begin
        cnt_n = cnt_q + 1'b1;
        if ((|(done_i & owner_q)) || !(|(req_i & owner_q))) begin
          // Normal completion or abandonment: no pulse, no penalty.
          state_n = RELEASE;
          owner_n = '0;
          idx_n   = '0;
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          state_n   = RELEASE;
          owner_n   = '0;
          idx_n     = '0;
          timeout_n = 1'b1;
          mask_n    = owner_q;
        end
      end

      RELEASE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      owner_q   <= owner_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      mask_q    <= mask_n;
      timeout_q <= timeout_n;
      err_q     <= err_n;
    end
  end

  assign owner_o     = owner_q;
  assign owner_idx_o = idx_q;
  assign busy_o      = (state_q == OWNED);
  assign timeout_o   = timeout_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_arbiter_lock.sv
// Scoreboard bench for arbiter_lock: a driver issues per-cycle stimulus and pushes
// the expected outputs from a tenure-level reference model; a monitor pops and
// compares on every falling edge.
module tb_arbiter_lock;

  localparam int NUM      = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDX_W    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NUM-1:0]   req_i, req_arb_o, gnt_i, done_i, owner_o;
  logic [IDX_W-1:0] owner_idx_o;
  logic             busy_o, timeout_o, err_o;
  logic             force_en;
  logic [NUM-1:0]   force_val;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    logic [NUM-1:0]   arb;
    logic [NUM-1:0]   owner;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             to;
    logic             err;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model: who owns the resource, how long they have held it,
  // whether we are in the one dead cycle after a release, who is banned.
  int m_owner;
  int m_held;
  int m_banned;
  bit m_gap;
  bit m_to;
  bit m_err;

  always #5 clk = ~clk;

  // Environment: fixed-priority arbiter (lowest index wins), overridable.
  always_comb begin
    gnt_i = force_en ? force_val : (req_arb_o & (~req_arb_o + 4'd1));
  end

  arbiter_lock #(.NUM(NUM), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .req_arb_o   (req_arb_o),
    .gnt_i       (gnt_i),
    .done_i      (done_i),
    .owner_o     (owner_o),
    .owner_idx_o (owner_idx_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .err_o       (err_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int first_set(input logic [NUM-1:0] v);
    for (int i = 0; i < NUM; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NUM-1:0] ban_mask();
    return (m_banned >= 0) ? NUM'(1 << m_banned) : '0;
  endfunction

  // One clock of stimulus; records what the DUT must show this cycle, then
  // advances the model by the rules for the chosen inputs.
  task automatic step(input logic [NUM-1:0] req, input logic [NUM-1:0] dn,
                      input bit fen, input logic [NUM-1:0] fval, input bit r);
    exp_t e;
    logic [NUM-1:0] arb, g;
    bit ended;
    @(posedge clk);
    #2;
    rst       = r;
    req_i     = req;
    done_i    = dn;
    force_en  = fen;
    force_val = fval;

    arb    = (m_owner < 0 && !m_gap) ? (req & ~ban_mask()) : '0;
    e.arb  = arb;
    e.owner = (m_owner >= 0) ? NUM'(1 << m_owner) : '0;
    e.idx  = (m_owner >= 0) ? IDX_W'(m_owner) : '0;
    e.busy = (m_owner >= 0);
    e.to   = m_to;
    e.err  = m_err;
    e.cyc  = cyc;
    sb.push_back(e);
    cyc++;

    m_to = 1'b0;
    if (r) begin
      m_owner = -1; m_held = 0; m_banned = -1; m_gap = 1'b0; m_err = 1'b0;
    end else if (m_owner >= 0) begin
      m_held++;
      ended = 1'b0;
      if (dn[m_owner]) ended = 1'b1;
      else if (!req[m_owner]) ended = 1'b1;
      else if (m_held == MAX_HOLD) begin
        ended = 1'b1; m_to = 1'b1; m_banned = m_owner;
      end
      if (ended) begin
        m_owner = -1; m_gap = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      g = fen ? fval : (first_set(arb) >= 0 ? NUM'(1 << first_set(arb)) : '0);
      if ($countones(g) == 1) begin
        m_owner = first_set(g); m_held = 0;
      end else if (g != '0) begin
        m_err = 1'b1;
      end
      m_banned = -1;
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("cycle%0d {arb,owner,idx,busy,to,err}", e.cyc),
            32'({req_arb_o, owner_o, owner_idx_o, busy_o, timeout_o, err_o}),
            32'({e.arb, e.owner, e.idx, e.busy, e.to, e.err}));
    end
  end

  initial begin
    logic [NUM-1:0] req, dn;
    rst = 1'b1; req_i = '0; done_i = '0; force_en = 1'b0; force_val = '0;
    m_owner = -1; m_held = 0; m_banned = -1; m_gap = 1'b0; m_to = 1'b0; m_err = 1'b0;

    step('0, '0, 0, '0, 1);
    step('0, '0, 0, '0, 1);

    // Grant to requester 1, done, re-grant.
    for (int i = 0; i < 3; i++) step(4'b0110, '0, 0, '0, 0);
    step(4'b0110, 4'b0010, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(4'b0110, '0, 0, '0, 0);
    step('0, '0, 0, '0, 0);
    step('0, '0, 0, '0, 0);

    // Single requester holds until timeout, then is masked for one slot.
    for (int i = 0; i < 14; i++) step(4'b0001, '0, 0, '0, 0);
    step('0, '0, 0, '0, 0);
    step('0, '0, 0, '0, 0);

    // Requester 0 times out; requester 1 wins the masked slot.
    for (int i = 0; i < 14; i++) step(4'b0011, '0, 0, '0, 0);
    step('0, '0, 0, '0, 0);
    step('0, '0, 0, '0, 0);

    // done coincides with the last allowed cycle: done wins, no mask.
    for (int i = 0; i < 24; i++) begin
      dn = (m_owner == 0 && m_held == MAX_HOLD - 1) ? 4'b0001 : 4'b0000;
      dn[2] = ($urandom_range(0, 3) == 0);
      step(4'b0001, dn, 0, '0, 0);
    end

    // Randomized traffic with occasional resets.
    req = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) req = NUM'($urandom_range(0, 15));
      dn = ($urandom_range(0, 4) == 0) ? NUM'($urandom_range(0, 15)) : '0;
      step(req, dn, 0, '0, ($urandom_range(0, 199) == 0));
    end

    // Non-one-hot grant sets sticky error; reset mid-ownership clears everything.
    step('0, '0, 0, '0, 1);
    step(4'b0101, '0, 1, 4'b0101, 0);
    step(4'b0101, '0, 1, 4'b0101, 0);
    for (int i = 0; i < 4; i++) step(4'b0100, '0, 0, '0, 0);
    step(4'b0100, '0, 0, '0, 1);
    step('0, '0, 0, '0, 0);
    step('0, '0, 0, '0, 0);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
